// File: rtl/i2c_codec_pkg.sv
// Shared definitions for the audio codec init sequencer: FSM states,
// codec register addresses and the default power-up register table.
package i2c_codec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_NEXT   = 3'd4,
        ST_VOLCHK = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [6:0] REG_LLIN   = 7'h00;
    localparam logic [6:0] REG_RLIN   = 7'h01;
    localparam logic [6:0] REG_LHP    = 7'h02;
    localparam logic [6:0] REG_RHP    = 7'h03;
    localparam logic [6:0] REG_APATH  = 7'h04;
    localparam logic [6:0] REG_DPATH  = 7'h05;
    localparam logic [6:0] REG_PWR    = 7'h06;
    localparam logic [6:0] REG_IFACE  = 7'h07;
    localparam logic [6:0] REG_SRATE  = 7'h08;
    localparam logic [6:0] REG_ACTIVE = 7'h09;
    localparam logic [6:0] REG_RESET  = 7'h0F;

    // Default table: {reg_addr[6:0], reg_data[8:0]} per command index.
    // The first nine entries form the normal bring-up; later slots are spares
    // for builds that raise NUM_CMD.
    function automatic logic [15:0] cfg_default(input logic [3:0] idx);
        case (idx)
            4'd0:    cfg_default = {REG_RESET,  9'h000};
            4'd1:    cfg_default = {REG_LLIN,   9'h017};
            4'd2:    cfg_default = {REG_RLIN,   9'h017};
            4'd3:    cfg_default = {REG_LHP,    9'h079};
            4'd4:    cfg_default = {REG_RHP,    9'h079};
            4'd5:    cfg_default = {REG_APATH,  9'h012};
            4'd6:    cfg_default = {REG_PWR,    9'h000};
            4'd7:    cfg_default = {REG_IFACE,  9'h042};
            4'd8:    cfg_default = {REG_ACTIVE, 9'h001};
            4'd9:    cfg_default = {REG_DPATH,  9'h000};
            4'd10:   cfg_default = {REG_SRATE,  9'h000};
            default: cfg_default = {REG_ACTIVE, 9'h001};
        endcase
    endfunction

endpackage

// File: rtl/i2c_codec_sequencer_if.sv
// Request/complete handshake between the sequencer and the I2C byte
// controller. The sequencer raises i2c_go with i2c_data stable and holds both
// until the controller pulses i2c_end; i2c_ack is valid in the i2c_end cycle
// (any bit set = a byte was NACKed).
interface i2c_codec_sequencer_if;
    logic [23:0] i2c_data;
    logic        i2c_go;
    logic        i2c_end;
    logic [2:0]  i2c_ack;

    modport master (output i2c_data, output i2c_go, input i2c_end, input i2c_ack);
    modport slave  (input i2c_data, input i2c_go, output i2c_end, output i2c_ack);
endinterface

// File: rtl/i2c_cfg_rom.sv
// Combinational lookup: command index -> codec register address and data.
module i2c_cfg_rom
    import i2c_codec_pkg::*;
(
    input  logic [3:0] i_idx,
    output logic [6:0] o_reg_addr,
    output logic [8:0] o_reg_data
);
    logic [15:0] w_entry;

    // Split the packed table word into address and data fields.
    always_comb begin
        w_entry    = cfg_default(i_idx);
        o_reg_addr = w_entry[15:9];
        o_reg_data = w_entry[8:0];
    end
endmodule

// File: rtl/i2c_codec_sequencer.sv
// Walks the codec init table over the byte controller with per-command NACK
// retries, then keeps the headphone volume registers tracking vol_l/vol_r.
module i2c_codec_sequencer
    import i2c_codec_pkg::*;
#(
    parameter int         NUM_CMD   = 9,
    parameter int         MAX_RETRY = 3,
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         VOL_W     = 7,
    parameter int         LVOL_IDX  = 3,
    parameter int         RVOL_IDX  = 4
) (
    input  logic                  clk_i2c,
    input  logic                  reset,
    input  logic                  start,
    input  logic [VOL_W-1:0]      vol_l,
    input  logic [VOL_W-1:0]      vol_r,
    i2c_codec_sequencer_if.master bus,
    output logic                  busy,
    output logic                  init_done,
    output logic                  error,
    output logic [3:0]            cmd_idx,
    output state_t                o_dbg_state
);
    localparam int             RW        = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [3:0]     L_IDX     = 4'(LVOL_IDX);
    localparam logic [3:0]     R_IDX     = 4'(RVOL_IDX);
    localparam logic [4:0]     N_CMD     = 5'(NUM_CMD);

    state_t           r_state;
    logic [23:0]      r_i2c_data;
    logic             r_go;
    logic             r_busy;
    logic             r_init_done;
    logic             r_error;
    logic [3:0]       r_cmd_idx;
    logic [RW-1:0]    r_retry;
    logic [2:0]       r_ack;
    logic [VOL_W-1:0] r_last_l;
    logic [VOL_W-1:0] r_last_r;
    logic [VOL_W-1:0] r_pend_vol;

    logic [6:0]       w_rom_addr;
    logic [8:0]       w_rom_data;
    logic [8:0]       w_reg_data;
    logic             w_is_l;
    logic             w_is_r;
    logic [4:0]       w_next_idx;

    i2c_cfg_rom u_rom (
        .i_idx      (r_cmd_idx),
        .o_reg_addr (w_rom_addr),
        .o_reg_data (w_rom_data)
    );

    assign w_next_idx = {1'b0, r_cmd_idx} + 5'd1;

    // Volume entries take the live request instead of the table default.
    always_comb begin
        w_is_l     = (r_cmd_idx == L_IDX);
        w_is_r     = (r_cmd_idx == R_IDX);
        w_reg_data = w_rom_data;
        if (w_is_l)
            w_reg_data = 9'(vol_l);
        else if (w_is_r)
            w_reg_data = 9'(vol_r);
    end

    // Sequencer FSM with all outputs registered. init_done doubles as the
    // mode flag: clear means walking the table, set means single volume writes.
    // last_l/last_r are committed only on an ACKed write so a failed volume
    // write is retried after the next start.
    always_ff @(posedge clk_i2c or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_i2c_data  <= '0;
            r_go        <= 1'b0;
            r_busy      <= 1'b0;
            r_init_done <= 1'b0;
            r_error     <= 1'b0;
            r_cmd_idx   <= '0;
            r_retry     <= '0;
            r_ack       <= '0;
            r_last_l    <= '0;
            r_last_r    <= '0;
            r_pend_vol  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Out of reset init_done is clear, so init starts on its own.
                    if (start || !r_init_done) begin
                        r_init_done <= 1'b0;
                        r_error     <= 1'b0;
                        r_retry     <= '0;
                        r_cmd_idx   <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_LOAD;
                    end else if (vol_l != r_last_l) begin
                        r_cmd_idx <= L_IDX;
                        r_busy    <= 1'b1;
                        r_state   <= ST_LOAD;
                    end else if (vol_r != r_last_r) begin
                        r_cmd_idx <= R_IDX;
                        r_busy    <= 1'b1;
                        r_state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_i2c_data <= {DEV_ADDR, 1'b0, w_rom_addr, w_reg_data};
                    r_pend_vol <= w_is_l ? vol_l : vol_r;
                    r_go       <= 1'b1;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Capture ack with end so CHECK does not depend on how long
                    // the controller holds it.
                    if (bus.i2c_end) begin
                        r_ack   <= bus.i2c_ack;
                        r_go    <= 1'b0;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (r_ack == 3'b000) begin
                        r_retry <= '0;
                        if (w_is_l)
                            r_last_l <= r_pend_vol;
                        else if (w_is_r)
                            r_last_r <= r_pend_vol;
                        r_state <= ST_NEXT;
                    end else if (r_retry < RETRY_MAX) begin
                        r_retry <= r_retry + 1'b1;
                        r_state <= ST_LOAD;
                    end else begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_ERR;
                    end
                end
                ST_NEXT: begin
                    if (r_init_done) begin
                        r_state <= ST_VOLCHK;
                    end else if (w_next_idx < N_CMD) begin
                        r_cmd_idx <= w_next_idx[3:0];
                        r_state   <= ST_LOAD;
                    end else begin
                        r_init_done <= 1'b1;
                        r_state     <= ST_VOLCHK;
                    end
                end
                ST_VOLCHK: begin
                    if (vol_l != r_last_l) begin
                        r_cmd_idx <= L_IDX;
                        r_state   <= ST_LOAD;
                    end else if (vol_r != r_last_r) begin
                        r_cmd_idx <= R_IDX;
                        r_state   <= ST_LOAD;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (start) begin
                        r_init_done <= 1'b0;
                        r_error     <= 1'b0;
                        r_retry     <= '0;
                        r_cmd_idx   <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_LOAD;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.i2c_data = r_i2c_data;
    assign bus.i2c_go   = r_go;
    assign busy         = r_busy;
    assign init_done    = r_init_done;
    assign error        = r_error;
    assign cmd_idx      = r_cmd_idx;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_i2c_codec_sequencer.sv
// Bench for the codec init sequencer: a byte-controller model answering each
// go after three cycles, a transfer log, and an expected-word queue built
// from the codec table and the volume-tracking rules.
module tb_i2c_codec_sequencer;
  import i2c_codec_pkg::*;

  localparam int NUM_CMD = 9;
  localparam int MAX_RETRY = 3;

  logic clk_i2c = 1'b0;
  logic reset;
  logic start;
  logic [6:0] vol_l;
  logic [6:0] vol_r;
  logic busy;
  logic init_done;
  logic error;
  logic [3:0] cmd_idx;
  state_t dbg_state;

  i2c_codec_sequencer_if bus ();

  i2c_codec_sequencer #(
    .NUM_CMD(NUM_CMD), .MAX_RETRY(MAX_RETRY), .DEV_ADDR(7'h1A),
    .VOL_W(7), .LVOL_IDX(3), .RVOL_IDX(4)
  ) dut (
    .clk_i2c(clk_i2c), .reset(reset), .start(start),
    .vol_l(vol_l), .vol_r(vol_r), .bus(bus),
    .busy(busy), .init_done(init_done), .error(error),
    .cmd_idx(cmd_idx), .o_dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk_i2c = ~clk_i2c;

  int total = 0;
  int bad = 0;

  logic [23:0] exp_q[$];
  logic [23:0] xfer_q[$];
  int log_base;

  logic [6:0] tb_reg [0:8];
  logic [8:0] tb_dat [0:8];
  logic [6:0] m_last_l;
  logic [6:0] m_last_r;
  logic m_err;

  // controller model knobs (main writes these, controller only reads)
  logic nack_en;
  logic [6:0] nack_reg;
  int nack_limit;
  int nack_mark;
  int stray_req;
  // controller-owned counters
  int nack_given = 0;
  int stray_done = 0;
  int ctl_cnt;

  typedef struct {
    logic [6:0] vl;
    logic [6:0] vr;
    int n_wr;
    logic [23:0] w0;
    logic [23:0] w1;
  } vol_vec_t;
  vol_vec_t vtab [0:4];

  // byte-controller model: end three cycles after go, ack held until next go
  initial begin
    bus.i2c_end = 1'b0;
    bus.i2c_ack = 3'b000;
    ctl_cnt = 0;
    forever begin
      @(posedge clk_i2c);
      #1;
      if (reset) begin
        ctl_cnt = 0;
        bus.i2c_end = 1'b0;
      end else if (bus.i2c_end) begin
        bus.i2c_end = 1'b0;
        ctl_cnt = 0;
      end else if (bus.i2c_go) begin
        if (ctl_cnt == 0) begin
          xfer_q.push_back(bus.i2c_data);
          bus.i2c_ack = 3'b000;
        end
        ctl_cnt++;
        if (ctl_cnt == 3) begin
          bus.i2c_end = 1'b1;
          if (nack_en && bus.i2c_data[15:9] == nack_reg &&
              (nack_limit < 0 || (nack_given - nack_mark) < nack_limit)) begin
            bus.i2c_ack = 3'b010;
            nack_given++;
          end else begin
            bus.i2c_ack = 3'b000;
          end
        end
      end else begin
        ctl_cnt = 0;
        if (stray_req != stray_done) begin
          bus.i2c_end = 1'b1;
          bus.i2c_ack = 3'b111;
          stray_done++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i2c);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, expv);
    end
  endtask

  function automatic logic [23:0] model_word(input int idx, input logic [6:0] vl, input logic [6:0] vr);
    logic [8:0] d;
    d = tb_dat[idx];
    if (idx == 3) d = {2'b00, vl};
    if (idx == 4) d = {2'b00, vr};
    return (24'h1A << 17) | (24'(tb_reg[idx]) << 9) | 24'(d);
  endfunction

  // expected transfers of a full init; nack_idx entry is NACKed `nacks` times
  task automatic model_init(input int nack_idx, input int nacks);
    bit stop;
    int reps;
    stop = 0;
    m_err = 1'b0;
    for (int i = 0; i < NUM_CMD && !stop; i++) begin
      reps = 1;
      if (i == nack_idx) reps = (nacks > MAX_RETRY) ? MAX_RETRY + 1 : nacks + 1;
      for (int r = 0; r < reps; r++) exp_q.push_back(model_word(i, vol_l, vol_r));
      if (i == nack_idx && nacks > MAX_RETRY) begin
        m_err = 1'b1;
        stop = 1;
      end else begin
        if (i == 3) m_last_l = vol_l;
        if (i == 4) m_last_r = vol_r;
      end
    end
  endtask

  task automatic compare_log(input string name);
    int n;
    int got_n;
    logic [23:0] g;
    n = exp_q.size();
    got_n = xfer_q.size() - log_base;
    check({name, " count"}, got_n, n);
    for (int i = 0; i < n; i++) begin
      g = (i < got_n) ? xfer_q[log_base + i] : 24'hxxxxxx;
      check($sformatf("%s word%0d", name, i), g, exp_q[i]);
    end
    exp_q.delete();
    log_base = xfer_q.size();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!(!busy && (init_done || error)) && n < budget) begin
      tick(1);
      n++;
    end
    check({name, " settle"}, 32'(n < budget), 1);
  endtask

  task automatic wait_go(input string name);
    int n;
    n = 0;
    while (!bus.i2c_go && n < 20) begin
      tick(1);
      n++;
    end
    check({name, " go seen"}, 32'(n < 20), 1);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] nl;
    logic [6:0] nr;
    reset = 1'b1;
    start = 1'b0;
    vol_l = 7'h79;
    vol_r = 7'h79;
    nack_en = 1'b0;
    nack_reg = 7'h00;
    nack_limit = 0;
    nack_mark = 0;
    stray_req = 0;
    log_base = 0;
    m_last_l = 7'h00;
    m_last_r = 7'h00;
    tb_reg[0] = 7'h0F; tb_dat[0] = 9'h000;
    tb_reg[1] = 7'h00; tb_dat[1] = 9'h017;
    tb_reg[2] = 7'h01; tb_dat[2] = 9'h017;
    tb_reg[3] = 7'h02; tb_dat[3] = 9'h079;
    tb_reg[4] = 7'h03; tb_dat[4] = 9'h079;
    tb_reg[5] = 7'h04; tb_dat[5] = 9'h012;
    tb_reg[6] = 7'h06; tb_dat[6] = 9'h000;
    tb_reg[7] = 7'h07; tb_dat[7] = 9'h042;
    tb_reg[8] = 7'h09; tb_dat[8] = 9'h001;
    vtab[0] = '{7'h50, 7'h60, 2, 24'h340450, 24'h340660};
    vtab[1] = '{7'h50, 7'h60, 0, 24'h000000, 24'h000000};
    vtab[2] = '{7'h50, 7'h11, 1, 24'h340611, 24'h000000};
    vtab[3] = '{7'h22, 7'h11, 1, 24'h340422, 24'h000000};
    vtab[4] = '{7'h00, 7'h7F, 2, 24'h340400, 24'h34067F};

    // reset state
    tick(3);
    check("rst go", bus.i2c_go, 0);
    check("rst data", bus.i2c_data, 0);
    check("rst busy", busy, 0);
    check("rst init_done", init_done, 0);
    check("rst error", error, 0);
    check("rst cmd_idx", cmd_idx, 0);
    check("rst state", dbg_state, ST_IDLE);

    // clean init
    reset = 1'b0;
    model_init(-1, 0);
    tick(1);
    check("boot state", dbg_state, ST_LOAD);
    check("boot cmd_idx", cmd_idx, 0);
    check("boot busy", busy, 1);
    check("boot go low", bus.i2c_go, 0);
    tick(1);
    check("boot go", bus.i2c_go, 1);
    check("boot first data", bus.i2c_data, 24'h341E00);
    wait_done("init", 400);
    compare_log("init");
    check("init done", init_done, 1);
    check("init busy", busy, 0);
    check("init error", error, 0);
    check("init go", bus.i2c_go, 0);

    // stray end outside WAIT
    stray_req++;
    tick(6);
    check("stray state", dbg_state, ST_IDLE);
    check("stray error", error, 0);
    check("stray busy", busy, 0);
    compare_log("stray");

    // table-driven volume updates
    for (int i = 0; i < 5; i++) begin
      vol_l = vtab[i].vl;
      vol_r = vtab[i].vr;
      if (vtab[i].n_wr >= 1) exp_q.push_back(vtab[i].w0);
      if (vtab[i].n_wr >= 2) exp_q.push_back(vtab[i].w1);
      m_last_l = vtab[i].vl;
      m_last_r = vtab[i].vr;
      tick(40);
      compare_log($sformatf("vtab%0d", i));
      check($sformatf("vtab%0d busy", i), busy, 0);
    end

    // randomized volume updates against the model
    for (int i = 0; i < 16; i++) begin
      nl = ($urandom_range(0, 3) == 0) ? vol_l : 7'($urandom_range(0, 127));
      nr = ($urandom_range(0, 3) == 0) ? vol_r : 7'($urandom_range(0, 127));
      vol_l = nl;
      vol_r = nr;
      if (nl != m_last_l) begin
        exp_q.push_back(24'h340400 | 24'(nl));
        m_last_l = nl;
      end
      if (nr != m_last_r) begin
        exp_q.push_back(24'h340600 | 24'(nr));
        m_last_r = nr;
      end
      tick(40);
      compare_log($sformatf("vrand%0d", i));
    end

    // retry: entry 2 NACKed twice
    nack_reg = 7'h01;
    nack_limit = 2;
    nack_mark = nack_given;
    nack_en = 1'b1;
    model_init(2, 2);
    pulse_start;
    wait_done("retry", 400);
    compare_log("retry");
    check("retry error", error, 0);
    check("retry init_done", init_done, 1);
    nack_en = 1'b0;

    // error: entry 5 always NACKed
    nack_reg = 7'h04;
    nack_limit = -1;
    nack_mark = nack_given;
    nack_en = 1'b1;
    model_init(5, 99);
    pulse_start;
    wait_done("err", 400);
    compare_log("err");
    check("err flag", error, m_err);
    check("err cmd_idx", cmd_idx, 5);
    check("err go", bus.i2c_go, 0);
    check("err busy", busy, 0);
    check("err init_done", init_done, 0);
    tick(5);
    check("err held", dbg_state, ST_ERR);
    nack_en = 1'b0;

    // restart from ERR, with a start pulse during WAIT that must be ignored
    model_init(-1, 0);
    pulse_start;
    check("rerun state", dbg_state, ST_LOAD);
    check("rerun cmd_idx", cmd_idx, 0);
    check("rerun error", error, 0);
    wait_go("rerun");
    check("rerun in wait", dbg_state, ST_WAIT);
    pulse_start;
    wait_done("rerun", 400);
    compare_log("rerun");
    check("rerun init_done", init_done, 1);
    check("rerun error end", error, 0);

    // reset in the middle of a transfer
    pulse_start;
    wait_go("mid");
    tick(1);
    #2;
    reset = 1'b1;
    #1;
    check("mid go async", bus.i2c_go, 0);
    check("mid busy", busy, 0);
    check("mid cmd_idx", cmd_idx, 0);
    check("mid state", dbg_state, ST_IDLE);
    tick(1);
    log_base = xfer_q.size();
    m_last_l = 7'h00;
    m_last_r = 7'h00;
    reset = 1'b0;
    model_init(-1, 0);
    tick(1);
    check("mid restart state", dbg_state, ST_LOAD);
    check("mid restart idx", cmd_idx, 0);
    wait_done("mid", 400);
    compare_log("mid");
    check("mid init_done", init_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_codec_sequencer.md
I2C_CODEC_SEQUENCER -- requirements
Module: i2c_codec_sequencer

Interface
REQ-001 SHALL have parameter NUM_CMD, default 9: number of init table entries (1..16).
REQ-002 SHALL have parameter MAX_RETRY, default 3: retries per command after a NACK.
REQ-003 SHALL have parameter DEV_ADDR, default 7'h1A: codec 7-bit I2C address.
REQ-004 SHALL have parameter VOL_W, default 7: volume field width (1..9).
REQ-005 SHALL have parameters LVOL_IDX, default 3, and RVOL_IDX, default 4: table indices of the left and right volume registers.
REQ-006 SHALL have port clk_i2c  in  1  controller clock (10 kHz nominal); one clock, all logic on its rising edge.
REQ-007 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port start  in  1  single-cycle pulse requesting a full re-initialisation.
REQ-009 SHALL have ports vol_l and vol_r  in  VOL_W  requested left and right volume.
REQ-010 SHALL have port i2c_data  out  24  {DEV_ADDR, 1'b0, reg_addr[6:0], reg_data[8:0]} to the byte controller.
REQ-011 SHALL have port i2c_go  out  1  transfer request to the byte controller.
REQ-012 SHALL have port i2c_end  in  1  transfer complete from the byte controller.
REQ-013 SHALL have port i2c_ack  in  3  per-byte NACK flags from the byte controller; any bit set means failure.
REQ-014 SHALL have ports busy, init_done and error  out  1  status flags, and cmd_idx  out  4  index of the current command.

Function
REQ-015 SHALL implement states IDLE, LOAD, WAIT, CHECK, NEXT, VOLCHK and ERR.
REQ-016 SHALL enter LOAD with cmd_idx=0 on the first clock after reset deassertion.
REQ-017 SHALL, in LOAD, register i2c_data from table entry cmd_idx, assert i2c_go, and move to WAIT (go visible 1 cycle after entering LOAD).
REQ-018 SHALL hold i2c_go and i2c_data stable in WAIT until i2c_end=1 is sampled, then clear i2c_go and move to CHECK.
REQ-019 SHALL, in CHECK, on i2c_ack==0 clear the retry count and go to NEXT; on nonzero ack with retry count < MAX_RETRY, increment the count and return to LOAD with the same index; otherwise go to ERR.
REQ-020 SHALL, in NEXT during init, increment cmd_idx and go to LOAD if cmd_idx+1 < NUM_CMD; else set init_done and go to VOLCHK.
REQ-021 SHALL substitute {zero-extend, vol_l} or {zero-extend, vol_r} as reg_data for entries LVOL_IDX and RVOL_IDX, sampled in LOAD, and record the sent value as last_l or last_r.
REQ-022 SHALL, in VOLCHK/IDLE after init, start a single-register write when vol_l != last_l (left first) or else when vol_r != last_r; both changed means two back-to-back writes, left then right.
REQ-023 SHALL not change last_l/last_r on a failed (ERR) write.
REQ-024 SHALL accept start only in IDLE or ERR: clear init_done, error and retry count, set cmd_idx=0, go to LOAD; start in any other state SHALL be ignored.
REQ-025 SHALL drive busy=1 in every state except IDLE and ERR.
REQ-026 SHALL hold error=1 in ERR with cmd_idx frozen at the failing entry; ERR leaves only on start or reset.
REQ-027 SHALL treat i2c_end asserted outside WAIT as ignored.

Reset
REQ-028 SHALL on reset force i2c_go=0, i2c_data=0, busy=0, init_done=0, error=0, cmd_idx=0, retry count=0, last_l=last_r=0, state IDLE, immediately, including mid-transfer.

Structure
REQ-029 SHALL take the state enumeration, codec register address constants and the default address/data table from shared package i2c_codec_pkg.
REQ-030 SHALL place the table lookup (index -> 7-bit address, 9-bit data) in combinational sub-module i2c_cfg_rom; volume substitution stays in the sequencer.

Verification
REQ-031 SHALL verify clean init: controller model always ACKs, i2c_end 3 cycles after go -> 9 transfers, the first i2c_data=24'h341E00, then init_done=1, busy=0.
REQ-032 SHALL verify retry: ack=3'b010 twice on entry 2 -> entry 2 sent 3 times, init completes, error=0.
REQ-033 SHALL verify error: entry 5 always NACKed -> 4 attempts, error=1, cmd_idx=5, i2c_go=0; a start pulse then reruns from index 0.
REQ-034 SHALL verify volume update: after init, vol_l 7'h79->7'h50 and vol_r 7'h79->7'h60 in the same cycle -> exactly two writes, 24'h3404_50 then 24'h3406_60 (reg 02 then 03).
REQ-035 SHALL verify reset mid-transfer: reset asserted in WAIT -> i2c_go=0 asynchronously; after release, init restarts at index 0.
REQ-036 SHALL verify ignored start: start pulsed during WAIT -> sequence unaffected, exactly NUM_CMD transfers.
